framebuffer_load: RTL and testbench

Write-side controller for the framebuffer's 8-bit port A. It takes the received-byte stream from the UART receiver, waits for a frame-sync byte, and writes the following BYTE_COUNT bytes into sequential framebuffer addresses. A per-byte watchdog aborts stalled transfers. Port B (display fetch) is unaffected; the framebuffer's dual-port RAM handles concurrency.

---
 rtl/framebuffer_load.sv | 117 +++++++++++
 tb/tb_framebuffer_load.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_load.sv
// framebuffer_load: UART byte stream to framebuffer port A writer.
// Waits for a sync byte, then writes one frame of bytes sequentially.
module framebuffer_load #(
    parameter int          ADDR_WIDTH     = 12,
    parameter int          BYTE_COUNT     = 4096,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd53200
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    output logic [7:0]            ram_data_out,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_clk_enable,
    output logic                  ram_write_enable,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(BYTE_COUNT - 1);
    localparam logic [15:0] RELOAD =
        TIMEOUT_CYCLES - 16'd1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [15:0]           wd_q, wd_d;
    logic [7:0]            data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Register state, datapath and the one-cycle status pulses.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. The reload cycle itself counts toward the
    // watchdog, so expiry lands TIMEOUT_CYCLES after the reloading strobe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wd_d    = wd_q;
        if (state_q != IDLE && wd_q != 16'd0)
            wd_d = wd_q - 16'd1;
        unique case (state_q)
            IDLE: begin
                if (rx_strobe && rx_data == SYNC_BYTE) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    wd_d    = RELOAD;
                end
            end
            LOAD: begin
                if (rx_strobe) begin
                    data_d  = rx_data;
                    addr_d  = idx_q;
                    wd_d    = RELOAD;
                    state_d = WRITE;
                end else if (wd_q == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (rx_strobe) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_data_out     = data_q;
    assign ram_address      = addr_q;
    assign ram_clk_enable   = (state_q == WRITE);
    assign ram_write_enable = (state_q == WRITE);
    assign busy             = (state_q != IDLE);
    assign frame_done       = done_q;
    assign error            = err_q;

endmodule

// File: tb/tb_framebuffer_load.sv
// tb_framebuffer_load: randomized bench with a timestamp-based model
// of frame loading, plus directed scenarios with literal expectations.
module tb_framebuffer_load;

    localparam int         AW   = 12;
    localparam int         BC   = 4096;
    localparam int         T    = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk_in    = 1'b0;
    logic          reset     = 1'b0;
    logic [7:0]    rx_data   = 8'h00;
    logic          rx_strobe = 1'b0;
    logic [7:0]    ram_data_out;
    logic [AW-1:0] ram_address;
    logic          ram_clk_enable;
    logic          ram_write_enable;
    logic          busy;
    logic          frame_done;
    logic          error;

    framebuffer_load #(
        .ADDR_WIDTH     (AW),
        .BYTE_COUNT     (BC),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (16'(T))
    ) dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_strobe        (rx_strobe),
        .ram_data_out     (ram_data_out),
        .ram_address      (ram_address),
        .ram_clk_enable   (ram_clk_enable),
        .ram_write_enable (ram_write_enable),
        .busy             (busy),
        .frame_done       (frame_done),
        .error            (error)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: whether a frame is open, next index, deadline and write slot.
    bit            active   = 1'b0;
    int            idx      = 0;
    int            wr_cyc   = -1;
    int            deadline = 0;
    logic [7:0]    e_data   = 8'h00;
    logic [AW-1:0] e_addr   = '0;
    logic          e_we     = 1'b0;
    logic          e_busy   = 1'b0;
    logic          e_done   = 1'b0;
    logic          e_err    = 1'b0;

    // Observed DUT events.
    int wa[$];
    int wdat[$];
    int wc[$];
    int done_cnt  = 0;
    int done_cyc  = -1;
    int done_busy = 1;
    int err_cnt   = 0;
    int err_cyc   = -1;
    int last_s    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs();
        return {7'd0, ram_data_out, ram_address, ram_clk_enable,
                ram_write_enable, busy, frame_done, error};
    endfunction

    function automatic logic [31:0] model_outs();
        return {7'd0, e_data, e_addr, e_we, e_we, e_busy,
                e_done, e_err};
    endfunction

    // Behavioural model: decides each next cycle from sampled inputs.
    initial begin
        bit         s;
        logic [7:0] d;
        int         c;
        forever begin
            @(posedge clk_in or negedge reset);
            if (!reset) begin
                active = 1'b0;
                wr_cyc = -1;
                e_data = '0;
                e_addr = '0;
                e_we   = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_err  = 1'b0;
                if (clk_in) cyc++;
                continue;
            end
            c = cyc;
            s = rx_strobe;
            d = rx_data;
            cyc++;
            e_we   = 1'b0;
            e_done = 1'b0;
            e_err  = 1'b0;
            if (!active) begin
                if (s && d == SYNC) begin
                    active   = 1'b1;
                    idx      = 0;
                    deadline = c + T;
                end
            end else if (c == wr_cyc) begin
                if (s) begin
                    e_err  = 1'b1;
                    active = 1'b0;
                end else if (idx == BC - 1) begin
                    e_done = 1'b1;
                    active = 1'b0;
                end else begin
                    idx++;
                end
            end else if (s) begin
                e_we     = 1'b1;
                e_addr   = AW'(idx);
                e_data   = d;
                wr_cyc   = c + 1;
                deadline = c + T;
            end else if (c >= deadline) begin
                e_err  = 1'b1;
                active = 1'b0;
            end
            e_busy = active;
        end
    end

    // Compare every cycle and log observed events.
    initial begin
        forever begin
            @(negedge clk_in);
            chk("outputs", outs(), model_outs());
            if (ram_write_enable) begin
                wa.push_back(int'(ram_address));
                wdat.push_back(int'(ram_data_out));
                wc.push_back(cyc);
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = int'(busy);
            end
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data   = b;
        rx_strobe = 1'b1;
        last_s    = cyc;
        @(posedge clk_in);
        #1;
        rx_strobe = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wdat.delete();
        wc.delete();
    endtask

    initial begin
        int s_k[3];
        int s_one;
        int e0;
        int gap;
        logic [7:0] b;

        idle(3);
        chk("reset_outputs", outs(), 32'd0);
        reset = 1'b1;
        idle(2);

        // Non-sync bytes in IDLE are ignored.
        send(8'h00);
        idle(4);
        send(8'h11);
        idle(4);
        chk("idle_no_write", wa.size(), 0);
        chk("idle_busy", busy, 1'b0);

        // Three spaced bytes land at addresses 0..2.
        clear_log();
        send(SYNC);
        idle(9);
        for (int k = 0; k < 3; k++) begin
            send(8'(k + 1));
            s_k[k] = last_s;
            idle(9);
        end
        chk("three_count", wa.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("three_addr", wa[k], k);
            chk("three_data", wdat[k], k + 1);
            chk("three_lat", wc[k] - s_k[k], 1);
        end
        chk("three_busy", busy, 1'b1);
        e0 = err_cnt;
        idle(T + 10);
        chk("three_abort", err_cnt - e0, 1);

        // Watchdog expiry after one data byte.
        clear_log();
        send(SYNC);
        idle(2);
        send(8'h3C);
        s_one = last_s;
        idle(T + 10);
        chk("wd_lat", err_cyc - s_one, T + 1);
        chk("wd_busy", busy, 1'b0);
        send(SYNC);
        idle(2);
        send(8'h77);
        idle(3);
        chk("restart_addr", wa[wa.size() - 1], 0);
        chk("restart_data", wdat[wa.size() - 1], 8'h77);
        idle(T + 10);

        // Back-to-back strobes: first written, second overruns.
        clear_log();
        send(SYNC);
        idle(3);
        send(8'h42);
        s_one = last_s;
        send(8'h43);
        idle(5);
        chk("ovr_count", wa.size(), 1);
        chk("ovr_data", wdat[0], 8'h42);
        chk("ovr_err_lat", err_cyc - s_one, 2);
        chk("ovr_busy", busy, 1'b0);

        // Full frame.
        clear_log();
        e0 = err_cnt;
        send(SYNC);
        idle(1);
        for (int i = 0; i < BC; i++) begin
            send(8'(i & 8'hFF));
            idle(1);
        end
        idle(5);
        chk("frame_count", wa.size(), BC);
        chk("frame_last_addr", wa[BC - 1], BC - 1);
        chk("frame_last_data", wdat[BC - 1], 8'hFF);
        chk("frame_done_cnt", done_cnt, 1);
        chk("frame_done_lat", done_cyc - last_s, 2);
        chk("frame_done_busy", done_busy, 0);
        chk("frame_no_err", err_cnt - e0, 0);

        // Reset in the middle of a load.
        send(SYNC);
        idle(1);
        for (int i = 0; i < 50; i++) begin
            send(8'(i + 3));
            idle(1);
        end
        reset = 1'b0;
        #1;
        chk("midreset_outputs", outs(), 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
        clear_log();
        send(SYNC);
        idle(2);
        send(8'h5C);
        idle(3);
        chk("postreset_count", wa.size(), 1);
        chk("postreset_addr", wa[0], 0);
        chk("postreset_data", wdat[0], 8'h5C);
        idle(T + 10);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 700; n++) begin
            b = ($urandom_range(0, 9) < 3) ? SYNC : 8'($urandom());
            send(b);
            case ($urandom_range(0, 9))
                0:       gap = 0;
                1:       gap = $urandom_range(T - 5, T + 5);
                default: gap = $urandom_range(1, 12);
            endcase
            idle(gap);
        end
        idle(T + 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
